// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR sequence generator.
// Optional seed loading in lfsr_seq_gen is enabled by defining LFSR_SEED_EN.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    HOLD
  } seq_state_e;

  // Taps 31, 29, 25 and 24 give a maximal-length 32-bit sequence.
  localparam logic [31:0] LFSR_DEFAULT_TAPS = 32'hA300_0000;
  localparam logic [31:0] LFSR_RESET_VAL    = 32'hFFFF_FFFF;

endpackage

// File: rtl/lfsr_core.sv
// Combinational Fibonacci LFSR stepper: advances the state by STEPS shifts and
// reports the bit emitted before each step (bits[0] is the oldest).
module lfsr_core #(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(32'hA300_0000),
  parameter int                STEPS  = 1
) (
  input  logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] next_state,
  output logic [STEPS-1:0]  bits
);

  logic [LFSR_W-1:0] walk;

  always_comb begin
    walk = state;
    bits = '0;
    for (int j = 0; j < STEPS; j++) begin
      bits[j] = walk[0];
      walk    = {walk[LFSR_W-2:0], ^(walk & TAPS)};
    end
    next_state = walk;
  end

endmodule

// File: rtl/lfsr_seq_gen.sv
// Free-running LFSR sampled into a SEQ_W-bit sequence on request, offered zero-padded
// under a valid/ready handshake. Define LFSR_SEED_EN to add the seed_load/seed ports.
module lfsr_seq_gen
  import lfsr_pkg::*;
#(
  parameter int                LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(LFSR_DEFAULT_TAPS),
  parameter int                SEQ_W        = 256,
  parameter int                OUT_W        = 288,
  parameter int                BITS_PER_CYC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             gen_en,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] random_sequence
`ifdef LFSR_SEED_EN
  ,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed
`endif
);

  localparam int SEQ_CYCLES = SEQ_W / BITS_PER_CYC;
  localparam int CNT_W      = $clog2(SEQ_CYCLES + 1);
  localparam int PAD_W      = OUT_W - SEQ_W;

  seq_state_e             state_q, state_d;
  logic [LFSR_W-1:0]      lfsr_q, lfsr_d, lfsr_step;
  logic [BITS_PER_CYC-1:0] step_bits;
  logic [BITS_PER_CYC-1:0] chunk;
  logic [SEQ_W-1:0]       seq_q, seq_d, seq_shift;
  logic [CNT_W-1:0]       count_q, count_d;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .STEPS  (BITS_PER_CYC)
  ) u_core (
    .state      (lfsr_q),
    .next_state (lfsr_step),
    .bits       (step_bits)
  );

  // A seed load overrides this cycle's step; zero is never allowed into the register
  // because the all-zero state would lock the LFSR up.
  always_comb begin
    lfsr_d = lfsr_step;
`ifdef LFSR_SEED_EN
    if (seed_load) begin
      lfsr_d = seed;
    end
`endif
    if (lfsr_d == '0) begin
      lfsr_d = '1;
    end
  end

  // Oldest bit of the cycle lands highest so the first collected bit ends up at the MSB.
  always_comb begin
    chunk = '0;
    for (int j = 0; j < BITS_PER_CYC; j++) begin
      chunk[BITS_PER_CYC-1-j] = step_bits[j];
    end
    seq_shift = (seq_q << BITS_PER_CYC) | SEQ_W'(chunk);
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GEN;
          seq_d   = '0;
          count_d = '0;
        end
      end
      GEN: begin
        if (gen_en) begin
          seq_d   = seq_shift;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(SEQ_CYCLES - 1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= '1;
      state_q <= IDLE;
      seq_q   <= '0;
      count_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      seq_q   <= seq_d;
      count_q <= count_d;
    end
  end

  assign busy            = (state_q == GEN);
  assign out_valid       = (state_q == HOLD);
  assign random_sequence = (state_q == HOLD) ? (OUT_W'(seq_q) << PAD_W) : '0;

endmodule
